// File: rtl/duft_ctrl_pkg.sv
// Shared types and constants for the multi-cycle DUFT ap_ctrl_hs access controller.
package duft_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_RST      = 3'd0,
    ST_IDLE     = 3'd1,
    ST_RD_ISSUE = 3'd2,
    ST_WR_ISSUE = 3'd3,
    ST_DONE     = 3'd4
  } state_t;

  localparam int CNT_W = 5;

  // Wide all-ones pattern; users slice off the width they need.
  localparam logic [255:0] IDLE_ADDR = '1;

  localparam logic [31:0] ERR_CODE = 32'hDEAD_BEEF;

endpackage

// File: rtl/duft_lat_cnt.sv
// Clearable up-counter with terminal compare, shared by the read and write issue phases.
module duft_lat_cnt
  import duft_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic [CNT_W-1:0] limit,
  output logic             hit
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign hit = en && (cnt == limit);

endmodule

// File: rtl/duft_ap_ctrl_hs_mc.sv
// Multi-cycle ap_ctrl_hs controller driving the prewrapped DUFT core's address/message ports.
// Optional address range check enabled by defining DUFT_ADDR_CHK_EN.
module duft_ap_ctrl_hs_mc
  import duft_ctrl_pkg::*;
#(
  parameter int                ADDR_W     = 32,
  parameter int                DATA_W     = 32,
  parameter int                RD_LAT     = 0,
  parameter int                WR_LAT     = 1,
  parameter logic [ADDR_W-1:0] ADDR_LIMIT = ADDR_W'(32'h0000_1000)
) (
  input  logic              clk,
  input  logic              ap_rst_n,
  input  logic              ap_start,
  input  logic              rd_wr,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] ap_return,
  output logic              ap_idle,
  output logic              ap_ready,
  output logic              ap_done,
  output logic [ADDR_W-1:0] core_rd_addr,
  output logic [ADDR_W-1:0] core_wr_addr,
  output logic [DATA_W-1:0] core_wr_msg,
  input  logic [DATA_W-1:0] core_rd_msg
);

  localparam logic [ADDR_W-1:0] NO_ADDR = IDLE_ADDR[ADDR_W-1:0];

  state_t            state;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic              issuing;
  logic              lat_hit;
  logic [CNT_W-1:0]  lat_limit;
  logic              addr_bad;

`ifdef DUFT_ADDR_CHK_EN
  localparam logic [DATA_W-1:0] ERR_VAL = DATA_W'(ERR_CODE);
  assign addr_bad = (addr >= ADDR_LIMIT);
`else
  assign addr_bad = 1'b0;
`endif

  assign issuing   = (state == ST_RD_ISSUE) || (state == ST_WR_ISSUE);
  // Write limit is WR_LAT-1 so the core sees exactly WR_LAT write cycles.
  assign lat_limit = (state == ST_RD_ISSUE) ? CNT_W'(RD_LAT) : CNT_W'(WR_LAT - 1);

  duft_lat_cnt u_lat_cnt (
    .clk   (clk),
    .rst_n (ap_rst_n),
    .clr   (!issuing),
    .en    (issuing),
    .limit (lat_limit),
    .hit   (lat_hit)
  );

  always_ff @(posedge clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state     <= ST_RST;
      ap_return <= '0;
      addr_q    <= '0;
      data_q    <= '0;
    end else begin
      case (state)
        ST_RST: state <= ST_IDLE;
        ST_IDLE: begin
          if (ap_start) begin
            addr_q <= addr;
            data_q <= wr_data;
            if (addr_bad) begin
              state <= ST_DONE;
`ifdef DUFT_ADDR_CHK_EN
              if (rd_wr) ap_return <= ERR_VAL;
`endif
            end else begin
              state <= rd_wr ? ST_RD_ISSUE : ST_WR_ISSUE;
            end
          end
        end
        ST_RD_ISSUE: begin
          if (lat_hit) begin
            ap_return <= core_rd_msg;
            state     <= ST_DONE;
          end
        end
        ST_WR_ISSUE: if (lat_hit) state <= ST_DONE;
        ST_DONE:     state <= ST_IDLE;
        default:     state <= ST_RST;
      endcase
    end
  end

  // Handshake and core ports decode straight from state so reset takes effect at once.
  assign ap_idle      = (state == ST_IDLE) && !ap_start;
  assign ap_done      = (state == ST_DONE);
  assign ap_ready     = (state == ST_DONE);
  assign core_rd_addr = (state == ST_RD_ISSUE) ? addr_q : NO_ADDR;
  assign core_wr_addr = (state == ST_WR_ISSUE) ? addr_q : NO_ADDR;
  assign core_wr_msg  = data_q;

endmodule
